alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//   Multi-cycle execute unit that consumes the 3-bit ALU control code produced by the ALU
//   control decoder and computes the result. It sits between the decoder/register-read stage
//   and writeback, and replaces the combinational ALU when shifts must be iterative.
//   Handshake is valid/ready on both the operation side and the result side.
// PARAMETERS
//   XLEN     32            operand/result width
//   SHAMT_W  $clog2(XLEN)  shift-amount width; taken from in_b[SHAMT_W-1:0]
// PORTS
//   in_clk          input   1        clock, all state on rising edge
//   in_rst_n        input   1        reset, synchronous, active-low
//   in_op_valid     input   1        operation request valid
//   out_op_ready    output  1        unit can accept an operation (high only in IDLE)
//   in_alu_control  input   3        operation code (encoding below)
//   in_a            input   XLEN     operand A (rs1)
//   in_b            input   XLEN     operand B (rs2 or immediate)
//   out_res_valid   output  1        result valid, held until accepted
//   in_res_ready    input   1        consumer accepts result
//   out_result      output  XLEN     result
//   out_zero        output  1        out_result == 0
// BEHAVIOUR
//   Clocking/reset: one clock; reset is synchronous and active-low.
//   Reset (in_rst_n=0 at edge): state=IDLE, out_res_valid=0, out_result=0, out_zero=1,
//     out_op_ready=1 on the following cycle; any in-flight operation is dropped, no result emitted.
//   Encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLL, 111 SRL.
//   Accept: in_op_valid & out_op_ready at an edge latches code, in_a, in_b.
//   States: IDLE -> (accept, non-shift) -> DONE; IDLE -> (accept, shift) -> SHIFT;
//     SHIFT -> SHIFT while count>0; SHIFT -> DONE when count==0; DONE -> IDLE on in_res_ready.
//   Non-shift ops: result registered at accept edge; out_res_valid=1 the next cycle (latency 1).
//   ADD/SUB: modulo 2^XLEN, carry/overflow discarded. SLT: signed compare, result 0 or 1
//     zero-extended.
//   Shifts: count loaded with in_b[SHAMT_W-1:0], upper bits of in_b ignored; one bit shifted
//     per cycle in SHIFT. Shamt=0 goes straight to DONE with result=in_a (latency 1).
//     Shamt=N>0: latency N+1 cycles from accept edge to out_res_valid. SRL shifts in zeros.
//   DONE: out_result/out_zero stable while out_res_valid=1 & in_res_ready=0. On the accepting
//     edge out_res_valid drops to 0; out_op_ready rises the next cycle. No back-to-back
//     accept in DONE.
//   in_op_valid while out_op_ready=0 is ignored (no queuing); in_a/in_b may change freely
//     after accept.
//   out_zero always equals (out_result==0), including after reset.
// STRUCTURE
//   Shared package: alu_control code localparams (the eight codes above), XLEN default,
//     state enum (IDLE, SHIFT, DONE). The ALU control decoder imports the same codes.
//   Single module plus one natural sub-module: alu_seq_shift_step (one-bit SLL/SRL step,
//     combinational), instantiated once inside the SHIFT datapath.
// TESTING
//   1. Reset: hold in_rst_n=0 two cycles mid-SHIFT (shamt=20) -> out_res_valid=0,
//      out_op_ready=1, out_result=0, out_zero=1, no stray result.
//   2. ADD 0xFFFFFFFF+1 -> out_result=0, out_zero=1, valid 1 cycle after accept;
//      SUB 5-7 -> 0xFFFFFFFE.
//   3. SLT: a=0xFFFFFFFF (-1), b=1 -> 1; a=1, b=0xFFFFFFFF -> 0; AND/OR/XOR of 0xF0F0,0x0FF0
//      -> 0x00F0/0xFFF0/0xFF00.
//   4. SLL a=1, b=0x0000_0105 (shamt 5) -> 0x20 after exactly 6 cycles; SRL a=0x8000_0000,
//      b=31 -> 1 after 32 cycles; shamt 0 -> a after 1 cycle.
//   5. Backpressure: in_res_ready=0 for 10 cycles -> result/valid stable, out_op_ready=0,
//      ops offered meanwhile ignored; release -> IDLE next cycle.
//   6. Random op stream with random valid/ready vs reference model: every accepted op yields
//      exactly one result, in order.

Source files
------------

// File: rtl/alu_seq_exec_pkg.sv
// Shared definitions for the sequential execute unit and the ALU control decoder:
// operation codes, default datapath width and the execute-unit state encoding.
package alu_seq_exec_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Both shift codes share the top two bits; everything else completes in one edge.
  function automatic logic is_shift(input logic [2:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_seq_shift_step.sv
// One-bit logical shift step: left (SLL) or right (SRL), zeros shifted in.
module alu_seq_shift_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         right_i,
  output logic [W-1:0] value_o
);

  assign value_o = right_i ? {1'b0, value_i[W-1:1]} : {value_i[W-2:0], 1'b0};

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute unit. Non-shift operations finish on the accept edge; shifts
// walk one bit per cycle through the shift-step datapath. Valid/ready on both sides.
module alu_seq_exec
  import alu_seq_exec_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  input  logic            in_op_valid,
  output logic            out_op_ready,
  input  logic [2:0]      in_alu_control,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_res_valid,
  input  logic            in_res_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero
);

  state_e              state_q, state_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [SHAMT_W-1:0]  count_q, count_d;
  logic                dir_right_q, dir_right_d;
  logic [XLEN-1:0]     alu_out;
  logic [XLEN-1:0]     step_out;
  logic [SHAMT_W-1:0]  shamt;

  assign shamt = in_b[SHAMT_W-1:0];

  // The shift register is result_q itself; one step per SHIFT cycle.
  alu_seq_shift_step #(.W(XLEN)) u_step (
    .value_i (result_q),
    .right_i (dir_right_q),
    .value_o (step_out)
  );

  // Single-edge operations computed straight from the live operands.
  always_comb begin
    alu_out = '0;
    case (in_alu_control)
      ALU_ADD: alu_out = in_a + in_b;
      ALU_SUB: alu_out = in_a - in_b;
      ALU_AND: alu_out = in_a & in_b;
      ALU_OR:  alu_out = in_a | in_b;
      ALU_XOR: alu_out = in_a ^ in_b;
      ALU_SLT: alu_out = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      default: alu_out = in_a;
    endcase
  end

  // Next-state and datapath control; a shift moving to DONE on its last step keeps
  // the shamt=N latency at N+1 edges counting the accept edge.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    count_d     = count_q;
    dir_right_d = dir_right_q;
    case (state_q)
      ST_IDLE: begin
        if (in_op_valid) begin
          if (is_shift(in_alu_control)) begin
            result_d    = in_a;
            count_d     = shamt;
            dir_right_d = (in_alu_control == ALU_SRL);
            state_d     = (shamt == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            result_d = alu_out;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        result_d = step_out;
        count_d  = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (in_res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      count_q     <= '0;
      dir_right_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      count_q     <= count_d;
      dir_right_q <= dir_right_d;
    end
  end

  assign out_op_ready  = (state_q == ST_IDLE);
  assign out_res_valid = (state_q == ST_DONE);
  assign out_result    = result_q;
  assign out_zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed and randomised checks for the sequential execute unit.
module tb_alu_seq_exec;
  import alu_seq_exec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  alu_control;
  logic [31:0] a, b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_seq_exec dut (
    .in_clk         (clk),
    .in_rst_n       (rst_n),
    .in_op_valid    (op_valid),
    .out_op_ready   (op_ready),
    .in_alu_control (alu_control),
    .in_a           (a),
    .in_b           (b),
    .out_res_valid  (res_valid),
    .in_res_ready   (res_ready),
    .out_result     (result),
    .out_zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Independent reference for one operation.
  function automatic logic [31:0] ref_alu(input logic [2:0] code, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [31:0] r;
    case (code)
      3'b000: r = x + y;
      3'b001: r = x - y;
      3'b010: r = x & y;
      3'b011: r = x | y;
      3'b100: r = x ^ y;
      3'b101: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b110: r = x << y[4:0];
      default: r = x >> y[4:0];
    endcase
    return r;
  endfunction

  // Issue one op, measure edges from accept (accept edge counts as 1) to result valid.
  task automatic do_op(input logic [2:0] code, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    int w;
    w = 0;
    while (!op_ready && w < 100) begin
      tick();
      w++;
    end
    op_valid    = 1'b1;
    alu_control = code;
    a           = x;
    b           = y;
    res_ready   = 1'b0;
    tick();
    op_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0BAD_F00D;
    lat      = 1;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
    res = result;
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    int          stray;
    logic [31:0] exp_q[$];
    int          accepted;
    int          produced;
    logic [2:0]  rc;
    logic [31:0] ra, rb, e;

    vecs[0]  = '{"add_wrap",  ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[1]  = '{"sub_neg",   ALU_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1};
    vecs[2]  = '{"slt_m1_1",  ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
    vecs[3]  = '{"slt_1_m1",  ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[4]  = '{"and",       ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1};
    vecs[5]  = '{"or",        ALU_OR,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1};
    vecs[6]  = '{"xor",       ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1};
    vecs[7]  = '{"sll5",      ALU_SLL, 32'h0000_0001, 32'h0000_0105, 32'h0000_0020, 6};
    vecs[8]  = '{"srl31",     ALU_SRL, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32};
    vecs[9]  = '{"sll0",      ALU_SLL, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1};
    vecs[10] = '{"srl0_hi",   ALU_SRL, 32'hF000_000F, 32'h0000_0020, 32'hF000_000F, 1};
    vecs[11] = '{"sll4",      ALU_SLL, 32'hFFFF_FFFF, 32'h0000_0004, 32'hFFFF_FFF0, 5};
    vecs[12] = '{"add_ovf",   ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1};
    vecs[13] = '{"slt_minmax", ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1};

    rst_n = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    alu_control = ALU_ADD; a = '0; b = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_op_ready", {31'd0, op_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);

    // Reset in the middle of a 20-step shift.
    op_valid = 1'b1; alu_control = ALU_SLL; a = 32'h0000_0001; b = 32'd20;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("midrst_op_ready", {31'd0, op_ready}, 32'd1);
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      if (res_valid) stray++;
      tick();
    end
    check("midrst_stray", stray, 32'd0);

    // Directed vector table.
    foreach (vecs[i]) begin
      do_op(vecs[i].code, vecs[i].a, vecs[i].b, r, lat);
      check({vecs[i].name, "_result"}, r, vecs[i].exp);
      check({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, (vecs[i].exp == 32'd0)});
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      $display("op %s code=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d",
               vecs[i].name, vecs[i].code, vecs[i].a, vecs[i].b, r, lat);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({vecs[i].name, "_released"}, {31'd0, op_ready}, 32'd1);
    end

    // Backpressure: hold the result for 10 cycles while other ops are offered.
    do_op(ALU_ADD, 32'd3, 32'd4, r, lat);
    check("bp_first", r, 32'd7);
    for (int i = 0; i < 10; i++) begin
      op_valid = 1'b1; alu_control = ALU_SUB; a = 32'd100 + i; b = 32'd1;
      tick();
      check("bp_result", result, 32'd7);
      check("bp_valid", {31'd0, res_valid}, 32'd1);
      check("bp_op_ready", {31'd0, op_ready}, 32'd0);
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_rel_valid", {31'd0, res_valid}, 32'd0);
    check("bp_rel_op_ready", {31'd0, op_ready}, 32'd1);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid) stray++;
      tick();
    end
    check("bp_no_queued", stray, 32'd0);
    $display("op backpressure held 10 cycles result=0x%08h", result);

    // Random op stream against the reference model with random handshakes.
    accepted = 0;
    produced = 0;
    for (int cyc = 0; cyc < 3000 && accepted < 40; cyc++) begin
      rc = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      op_valid = ($urandom_range(0, 2) != 0);
      alu_control = rc; a = ra; b = rb;
      res_ready = ($urandom_range(0, 1) == 1);
      if (op_valid && op_ready) begin
        exp_q.push_back(ref_alu(rc, ra, rb));
        accepted++;
      end
      if (res_valid && res_ready) begin
        produced++;
        if (exp_q.size() == 0) begin
          check("rand_extra_result", result, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rand_result", result, e);
          $display("op random #%0d result=0x%08h expected=0x%08h", produced, result, e);
        end
      end
      tick();
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      if (res_valid) begin
        produced++;
        e = exp_q.pop_front();
        check("rand_result", result, e);
        $display("op random #%0d result=0x%08h expected=0x%08h", produced, result, e);
      end
      tick();
    end
    check("rand_count", produced, accepted);
    check("rand_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
